// File: rtl/sram_controller.sv
`default_nettype none
// ============================================================================
// Module   : sram_controller
// Purpose  : Bridges the 32-bit pipeline data port to a 16-bit asynchronous
//            SRAM as two timed half-accesses (low half first), stalling via ready.
// Revision : 1.0 - initial release
// ============================================================================
module sram_controller #(
    parameter logic [31:0] BASE_ADDR   = 32'd1024,
    parameter int          WAIT_CYCLES = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic [17:0] sram_addr,
    output logic [15:0] sram_dq_out,
    output logic        sram_dq_oe,
    input  logic [15:0] sram_dq_in,
    output logic        sram_we_n,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_ub_n,
    output logic        sram_lb_n
);

    localparam int c_cnt_w = (WAIT_CYCLES > 2) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOW  = 2'd1,
        S_HIGH = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [c_cnt_w-1:0]   w_cnt_next;
    logic                 r_is_write;
    logic [16:0]          r_word;
    logic [31:0]          r_wdata;
    logic [31:0]          r_read_data;
    logic                 w_latch;
    logic                 w_cap_lo;
    logic                 w_cap_hi;
    logic                 w_half_end;
    logic [31:0]          w_off;
    logic                 w_unused;

    // Sub-BASE_ADDR addresses wrap modulo 2^32; only bits [18:2] select a word.
    assign w_off    = address - BASE_ADDR;
    assign w_unused = ^{w_off[31:19], w_off[1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_is_write  <= 1'b0;
            r_word      <= '0;
            r_wdata     <= '0;
            r_read_data <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (w_latch) begin
                r_is_write <= wr_en;
                r_word     <= w_off[18:2];
                r_wdata    <= write_data;
            end
            if (w_cap_lo) begin
                r_read_data[15:0] <= sram_dq_in;
            end
            if (w_cap_hi) begin
                r_read_data[31:16] <= sram_dq_in;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_latch      = 1'b0;
        w_cap_lo     = 1'b0;
        w_cap_hi     = 1'b0;
        w_half_end   = (r_cnt == c_cnt_last);
        ready        = 1'b0;
        sram_addr    = '0;
        sram_dq_out  = '0;
        sram_dq_oe   = 1'b0;
        sram_we_n    = 1'b1;

        case (r_state)
            S_IDLE: begin
                ready = ~wr_en & ~rd_en;
                if (wr_en | rd_en) begin
                    w_latch      = 1'b1;
                    w_state_next = S_LOW;
                    w_cnt_next   = '0;
                end
            end
            S_LOW: begin
                sram_addr   = {r_word, 1'b0};
                sram_dq_oe  = r_is_write;
                sram_dq_out = r_is_write ? r_wdata[15:0] : 16'h0000;
                // Strobe released in the last cycle so address/data are held past WE rise.
                sram_we_n   = ~(r_is_write & ~w_half_end);
                if (w_half_end) begin
                    w_cap_lo     = ~r_is_write;
                    w_state_next = S_HIGH;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + c_cnt_w'(1);
                end
            end
            S_HIGH: begin
                sram_addr   = {r_word, 1'b1};
                sram_dq_oe  = r_is_write;
                sram_dq_out = r_is_write ? r_wdata[31:16] : 16'h0000;
                sram_we_n   = ~(r_is_write & ~w_half_end);
                if (w_half_end) begin
                    w_cap_hi     = ~r_is_write;
                    w_state_next = S_DONE;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + c_cnt_w'(1);
                end
            end
            S_DONE: begin
                ready        = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign read_data = r_read_data;
    assign sram_ce_n = 1'b0;
    assign sram_oe_n = 1'b0;
    assign sram_ub_n = 1'b0;
    assign sram_lb_n = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_sram_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_controller
// Purpose  : Self-checking bench for sram_controller with a behavioural SRAM
//            and a read-data scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_controller;

    localparam int          W    = 5;
    localparam logic [31:0] BASE = 32'd1024;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic        sram_dq_oe;
    logic [15:0] sram_dq_in;
    logic        sram_we_n;
    logic        sram_ce_n;
    logic        sram_oe_n;
    logic        sram_ub_n;
    logic        sram_lb_n;

    sram_controller #(
        .BASE_ADDR   (BASE),
        .WAIT_CYCLES (W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .rd_en       (rd_en),
        .address     (address),
        .write_data  (write_data),
        .read_data   (read_data),
        .ready       (ready),
        .sram_addr   (sram_addr),
        .sram_dq_out (sram_dq_out),
        .sram_dq_oe  (sram_dq_oe),
        .sram_dq_in  (sram_dq_in),
        .sram_we_n   (sram_we_n),
        .sram_ce_n   (sram_ce_n),
        .sram_oe_n   (sram_oe_n),
        .sram_ub_n   (sram_ub_n),
        .sram_lb_n   (sram_lb_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural asynchronous SRAM: combinational read, write while WE is low.
    logic [15:0] sram_mem [0:262143];
    assign sram_dq_in = sram_mem[sram_addr];
    always @(posedge clk) begin
        if (!sram_we_n) sram_mem[sram_addr] <= sram_dq_oe ? sram_dq_out : 16'h0bad;
    end

    int          n_total = 0;
    int          n_bad   = 0;
    logic [31:0] sb_q[$];
    logic [31:0] ref_mem [logic [16:0]];
    logic [31:0] last_rd;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [16:0] word_of(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return off[18:2];
    endfunction

    // Entered at cycle 0 (just after an edge); returns in the cycle after DONE.
    task automatic access(input logic wr, input logic rd, input logic [31:0] a,
                          input logic [31:0] d, input string nm);
        logic [16:0] wd;
        logic [31:0] exp;
        logic        hh;
        int          cnt;
        wd = word_of(a);
        wr_en = wr; rd_en = rd; address = a; write_data = d;
        if (wr) begin
            ref_mem[wd] = d;
            exp = last_rd;
        end else begin
            exp = ref_mem.exists(wd) ? ref_mem[wd] : 32'h0;
            last_rd = exp;
        end
        sb_q.push_back(exp);
        #1;
        chk($sformatf("%s_rdy_c0", nm), {31'b0, ready}, 32'd0);
        for (int c = 1; c <= 2*W+1; c++) begin
            @(posedge clk); #1;
            if (c <= 2*W) begin
                hh  = (c > W);
                cnt = (c - 1) % W;
                chk($sformatf("%s_rdy_c%0d", nm, c), {31'b0, ready}, 32'd0);
                chk($sformatf("%s_addr_c%0d", nm, c), {14'b0, sram_addr}, {14'b0, wd, hh});
                chk($sformatf("%s_oe_c%0d", nm, c), {31'b0, sram_dq_oe}, {31'b0, wr});
                chk($sformatf("%s_wen_c%0d", nm, c), {31'b0, sram_we_n},
                    (wr && cnt != W-1) ? 32'd0 : 32'd1);
                if (wr)
                    chk($sformatf("%s_dq_c%0d", nm, c), {16'b0, sram_dq_out},
                        {16'b0, (hh ? d[31:16] : d[15:0])});
            end else begin
                chk($sformatf("%s_rdy_done", nm), {31'b0, ready}, 32'd1);
                chk($sformatf("%s_addr_done", nm), {14'b0, sram_addr}, 32'd0);
                chk($sformatf("%s_wen_done", nm), {31'b0, sram_we_n}, 32'd1);
                if (sb_q.size() == 0) chk($sformatf("%s_sb_underflow", nm), 32'd1, 32'd0);
                else chk($sformatf("%s_rdata", nm), read_data, sb_q.pop_front());
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input string nm);
        wr_en = 1'b0; rd_en = 1'b0;
        #1;
        chk($sformatf("%s_rdy_idle", nm), {31'b0, ready}, 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; address = '0; write_data = '0;
        last_rd = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_rdata", read_data, 32'd0);
        chk("rst_wen", {31'b0, sram_we_n}, 32'd1);
        chk("rst_oe", {31'b0, sram_dq_oe}, 32'd0);
        chk("rst_rdy", {31'b0, ready}, 32'd1);
        chk("rst_addr", {14'b0, sram_addr}, 32'd0);
        @(posedge clk); #1;

        access(1'b1, 1'b0, BASE + 32'd8, 32'hDEADBEEF, "wr1");
        idle("wr1");
        access(1'b0, 1'b1, BASE + 32'd8, 32'h0, "rd1");
        idle("rd1");
        access(1'b1, 1'b1, BASE + 32'd16, 32'h12345678, "prio");
        idle("prio");
        access(1'b0, 1'b1, BASE + 32'd16, 32'h0, "rd2");
        idle("rd2");
        access(1'b1, 1'b0, 32'h0000_0000, 32'hA5A55A5A, "wrap");
        idle("wrap");

        // Abort a read of 0xDEADBEEF in cycle 7, after its low half landed.
        rd_en = 1'b1; address = BASE + 32'd8;
        repeat (7) @(posedge clk);
        #1;
        chk("abort_partial", read_data, {last_rd[31:16], 16'hBEEF});
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_rdata", read_data, 32'd0);
        chk("abort_rdy_req", {31'b0, ready}, 32'd0);
        rst = 1'b0; rd_en = 1'b0;
        #1;
        chk("abort_rdy", {31'b0, ready}, 32'd1);
        chk("abort_wen", {31'b0, sram_we_n}, 32'd1);
        last_rd = 32'd0;
        @(posedge clk); #1;

        access(1'b1, 1'b0, BASE + 32'h23, 32'hCAFEF00D, "b2b_wr");
        access(1'b0, 1'b1, BASE + 32'h20, 32'h0, "b2b_rd");
        idle("b2b");

        chk("sb_empty", sb_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
